// File: rtl/burrito_pkg.sv
// Shared constants, instruction layout and FSM encoding for the Burrito fetch/issue sequencer.
package burrito_pkg;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned INSTR_W = 20;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 5;

  localparam int unsigned WE_BIT  = 19;
  localparam int unsigned OP_MSB  = 18;
  localparam int unsigned OP_LSB  = 15;
  localparam int unsigned RS1_MSB = 14;
  localparam int unsigned RS1_LSB = 10;
  localparam int unsigned RS2_MSB = 9;
  localparam int unsigned RS2_LSB = 5;
  localparam int unsigned RD_MSB  = 4;
  localparam int unsigned RD_LSB  = 0;

  localparam logic [OP_W-1:0] HALT_OP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic             we;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } instr_t;

  function automatic logic word_is_halt(input logic [INSTR_W-1:0] word);
    return word[OP_MSB:OP_LSB] == HALT_OP;
  endfunction

endpackage

// File: rtl/burrito_if.sv
// Instruction RAM port and datapath issue handshake of the Burrito sequencer.
interface burrito_if;
  import burrito_pkg::*;

  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_dout;
  logic               issue_valid;
  logic               ex_ready;
  logic               we_out;
  logic [OP_W-1:0]    op_out;
  logic [REG_W-1:0]   rs1_out;
  logic [REG_W-1:0]   rs2_out;
  logic [REG_W-1:0]   rd_out;

  modport master (
    output mem_addr, mem_we, issue_valid, we_out, op_out, rs1_out, rs2_out, rd_out,
    input  mem_dout, ex_ready
  );

  modport slave (
    input  mem_addr, mem_we, issue_valid, we_out, op_out, rs1_out, rs2_out, rd_out,
    output mem_dout, ex_ready
  );
endinterface

// File: rtl/burrito_decode.sv
// Splits the latched instruction into datapath fields, forced to zero unless issuing.
module burrito_decode
  import burrito_pkg::*;
(
  input  instr_t           ir,
  input  logic             issue_valid,
  output logic             we_c,
  output logic [OP_W-1:0]  op_c,
  output logic [REG_W-1:0] rs1_c,
  output logic [REG_W-1:0] rs2_c,
  output logic [REG_W-1:0] rd_c,
  output logic             is_halt_c
);

  assign is_halt_c = (ir.op == HALT_OP);
  assign we_c      = issue_valid & ir.we;
  assign op_c      = issue_valid ? ir.op  : '0;
  assign rs1_c     = issue_valid ? ir.rs1 : '0;
  assign rs2_c     = issue_valid ? ir.rs2 : '0;
  assign rd_c      = issue_valid ? ir.rd  : '0;

endmodule

// File: rtl/burrito_sequencer.sv
// Fetch/issue controller: walks instruction RAM from 0 to a captured last address,
// issuing each word over a valid/ready handshake and pulsing done at the end.
module burrito_sequencer
  import burrito_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  burrito_if.master         bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  state_e            state;
  instr_t            ir;
  logic [ADDR_W-1:0] last_q;
  logic              issue_valid;
  logic              is_halt_c;

  burrito_decode u_decode (
    .ir          (ir),
    .issue_valid (issue_valid),
    .we_c        (bus.we_out),
    .op_c        (bus.op_out),
    .rs1_c       (bus.rs1_out),
    .rs2_c       (bus.rs2_out),
    .rd_c        (bus.rd_out),
    .is_halt_c   (is_halt_c)
  );

  assign bus.mem_addr    = pc;
  assign bus.mem_we      = 1'b0;
  assign bus.issue_valid = issue_valid;

  // issue_valid is decided at fetch time so a HALT word is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      ir          <= '0;
      last_q      <= '0;
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_FETCH;
            pc     <= '0;
            last_q <= last_addr;
            busy   <= 1'b1;
          end
        end
        ST_FETCH: begin
          ir          <= instr_t'(bus.mem_dout);
          issue_valid <= ~word_is_halt(bus.mem_dout);
          state       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (is_halt_c) begin
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else if (bus.ex_ready) begin
            issue_valid <= 1'b0;
            if (pc == last_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              pc    <= pc + ADDR_W'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burrito_sequencer.sv
// Self-checking bench for burrito_sequencer: event-timed reference model plus directed/random programs.
module tb_burrito_sequencer;
  import burrito_pkg::*;

  localparam int NEVER = 32'h7fff_ffff;
  localparam int DEPTH = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;

  burrito_if bus ();

  burrito_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last_addr (last_addr),
    .bus       (bus),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [INSTR_W-1:0] ram [DEPTH];
  assign bus.mem_dout = ram[bus.mem_addr];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int ready_mode = 0;
  int stall_left = 0;

  // Reference model: timestamps of the next expected event, not machine states.
  bit                m_active   = 1'b0;
  bit                m_in_issue = 1'b0;
  int                m_start_cyc = 0;
  int                m_fetch_cyc = 0;
  int                m_done_cyc  = NEVER;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [ADDR_W-1:0] m_last = '0;

  int n_issue = 0;
  int n_done = 0;
  int n_hold2 = 0;
  int start_seen = 0;
  int done_seen = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    logic [INSTR_W-1:0] w;
    logic ev, eb, ed;
    cyc++;
    case (ready_mode)
      0: bus.ex_ready = 1'b1;
      1: bus.ex_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (bus.issue_valid && pc == ADDR_W'(2) && stall_left > 0) begin
          bus.ex_ready = 1'b0;
          stall_left--;
        end else begin
          bus.ex_ready = 1'b1;
        end
      end
    endcase

    if (m_active && !m_in_issue && cyc == m_fetch_cyc) begin
      w = ram[m_addr];
      if (w[OP_MSB:OP_LSB] == HALT_OP) m_done_cyc = cyc + 1;
      else m_in_issue = 1'b1;
    end
    ev = m_in_issue;
    ed = (cyc == m_done_cyc);
    eb = m_active && cyc > m_start_cyc && cyc < m_done_cyc;
    w  = ev ? ram[m_addr] : '0;

    check("issue_valid", 32'(bus.issue_valid), 32'(ev));
    check("busy", 32'(busy), 32'(eb));
    check("done", 32'(done), 32'(ed));
    check("pc", 32'(pc), 32'(m_addr));
    check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    check("mem_we", 32'(bus.mem_we), 32'd0);
    check("we_out", 32'(bus.we_out), 32'(w[WE_BIT]));
    check("op_out", 32'(bus.op_out), 32'(w[OP_MSB:OP_LSB]));
    check("rs1_out", 32'(bus.rs1_out), 32'(w[RS1_MSB:RS1_LSB]));
    check("rs2_out", 32'(bus.rs2_out), 32'(w[RS2_MSB:RS2_LSB]));
    check("rd_out", 32'(bus.rd_out), 32'(w[RD_MSB:RD_LSB]));

    if (bus.issue_valid && bus.ex_ready) n_issue++;
    if (bus.issue_valid && pc == ADDR_W'(2)) n_hold2++;
    if (done) begin
      n_done++;
      done_seen = cyc;
    end

    if (rst) begin
      m_active   = 1'b0;
      m_in_issue = 1'b0;
      m_addr     = '0;
      m_done_cyc = NEVER;
    end else if (!m_active) begin
      if (start) begin
        m_active    = 1'b1;
        m_in_issue  = 1'b0;
        m_start_cyc = cyc;
        m_fetch_cyc = cyc + 2;
        m_done_cyc  = NEVER;
        m_addr      = '0;
        m_last      = last_addr;
        start_seen  = cyc;
      end
    end else begin
      if (m_in_issue && bus.ex_ready) begin
        m_in_issue = 1'b0;
        if (m_addr == m_last) m_done_cyc = cyc + 1;
        else begin
          m_addr      = m_addr + ADDR_W'(1);
          m_fetch_cyc = cyc + 2;
        end
      end
      if (cyc == m_done_cyc) m_active = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    n_issue = 0;
    n_done  = 0;
    n_hold2 = 0;
  endtask

  // Waits for done; when stray is set, pokes start and last_addr while the program runs.
  task automatic wait_done(input string name, input int budget, input bit stray);
    int k = 0;
    while (!done && k < budget) begin
      if (stray) begin
        start     = ($urandom_range(0, 5) == 0);
        last_addr = ADDR_W'($urandom);
      end
      tick(1);
      k++;
    end
    start = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
    tick(1);
  endtask

  task automatic run(input string name, input logic [ADDR_W-1:0] la, input bit stray);
    clear_counts();
    last_addr = la;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(name, 200, stray);
  endtask

  function automatic logic [INSTR_W-1:0] rand_word(input bit allow_halt);
    logic [INSTR_W-1:0] x;
    x = INSTR_W'($urandom);
    if (!allow_halt && x[OP_MSB:OP_LSB] == HALT_OP) x[OP_MSB] = 1'b0;
    return x;
  endfunction

  task automatic load_program();
    ram[0] = 20'h8_0443;
    ram[1] = 20'h0_8862;
    ram[2] = 20'h9_0C83;
    ram[3] = 20'h1_10A4;
    ram[4] = 20'hA_14C5;
    ram[5] = 20'h2_18E6;
    ram[6] = 20'h0_0000;
    ram[7] = 20'h0_0000;
  endtask

  initial begin
    int exp_n;
    int k;
    rst = 1'b1;
    start = 1'b0;
    last_addr = '0;
    load_program();

    // Reset then idle
    tick(2);
    rst = 1'b0;
    clear_counts();
    tick(10);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_pc", 32'(pc), 32'd0);
    check("idle_issues", 32'(n_issue), 32'd0);

    // Full program, ex_ready held high
    run("full", 3'd5, 1'b0);
    check("full_issues", 32'(n_issue), 32'd6);
    check("full_latency", 32'(done_seen - start_seen), 32'd13);
    check("full_pc", 32'(pc), 32'd5);
    check("full_done_cnt", 32'(n_done), 32'd1);

    // Backpressure at pc 2
    ready_mode = 2;
    stall_left = 4;
    run("stall", 3'd5, 1'b0);
    ready_mode = 0;
    check("stall_hold", 32'(n_hold2), 32'd5);
    check("stall_issues", 32'(n_issue), 32'd6);
    check("stall_latency", 32'(done_seen - start_seen), 32'd17);

    // Early HALT at address 3
    ram[3] = {1'b0, HALT_OP, 15'h1234};
    run("halt", 3'd5, 1'b0);
    check("halt_issues", 32'(n_issue), 32'd3);
    check("halt_pc", 32'(pc), 32'd3);
    check("halt_latency", 32'(done_seen - start_seen), 32'd9);
    tick(3);
    check("halt_pc_hold", 32'(pc), 32'd3);

    // Top address, no wrap
    for (int i = 0; i < DEPTH; i++) ram[i] = rand_word(1'b0);
    run("top", 3'd7, 1'b0);
    check("top_issues", 32'(n_issue), 32'd8);
    check("top_pc", 32'(pc), 32'd7);
    check("top_done_cnt", 32'(n_done), 32'd1);
    check("top_latency", 32'(done_seen - start_seen), 32'd17);
    tick(4);
    check("top_pc_hold", 32'(pc), 32'd7);

    // Reset during the ISSUE of pc 4
    load_program();
    clear_counts();
    last_addr = 3'd5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    k = 0;
    while (!(bus.issue_valid && pc == 3'd4) && k < 50) begin
      tick(1);
      k++;
    end
    check("rst_reach_pc4", 32'(bus.issue_valid && pc == 3'd4), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick(20);
    check("rst_no_done", 32'(n_done), 32'd0);

    // Start while busy is ignored, late last_addr change has no effect
    clear_counts();
    last_addr = 3'd5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    start = 1'b1;
    last_addr = 3'd1;
    tick(1);
    start = 1'b0;
    wait_done("restart", 200, 1'b0);
    check("restart_issues", 32'(n_issue), 32'd6);
    check("restart_pc", 32'(pc), 32'd5);
    check("restart_done_cnt", 32'(n_done), 32'd1);

    // Random programs with random backpressure and stray starts
    ready_mode = 1;
    for (int p = 0; p < 25; p++) begin
      logic [ADDR_W-1:0] la;
      logic [INSTR_W-1:0] x;
      for (int i = 0; i < DEPTH; i++) ram[i] = rand_word($urandom_range(0, 7) == 0);
      la = ADDR_W'($urandom);
      exp_n = 0;
      for (int a = 0; a <= int'(la); a++) begin
        x = ram[a];
        if (x[OP_MSB:OP_LSB] == HALT_OP) break;
        exp_n++;
      end
      run("rand", la, 1'b1);
      check("rand_issues", 32'(n_issue), 32'(exp_n));
      check("rand_done_cnt", 32'(n_done), 32'd1);
      tick($urandom_range(0, 3));
    end
    ready_mode = 0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
